// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the fast-monitoring spy-buffer playback path.
package fm_sb_pkg;

    localparam int MON_DW_MAX        = 256;
    localparam int PB_MODE_WIDTH     = 2;
    localparam int PB_FIFO_DEPTH_DEF = 4;

    // Playback mode as programmed by software.
    typedef enum logic [PB_MODE_WIDTH-1:0] {
        PB_OFF     = 2'b00,
        PB_ONESHOT = 2'b01,
        PB_LOOP    = 2'b10,
        PB_STEP    = 2'b11
    } pb_mode_t;

    // Playback sequencer state.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } pb_state_t;

endpackage

// File: rtl/fm_sb_playback_if.sv
// SB memory read port plus playback valid/ready stream.
// master: playback engine; slave: memory and downstream stream mux.
interface fm_sb_playback_if #(
    parameter int DW = 256,
    parameter int AW = 10
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] pb_data;
    logic          pb_vld;
    logic          pb_ready;

    modport master (
        output mem_rd_en, mem_rd_addr, pb_data, pb_vld,
        input  mem_rd_data, pb_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, pb_data, pb_vld,
        output mem_rd_data, pb_ready
    );
endinterface

// File: rtl/fm_sb_pb_fifo.sv
// Show-ahead output FIFO for playback words, with occupancy count and flush.
module fm_sb_pb_fifo #(
    parameter int DW    = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage write.
    // NOTE: the storage array is never reset; count says which entries are valid, so only pointers reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy update; flush empties the FIFO in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/fm_sb_playback.sv
// Spy-buffer playback engine: reads preloaded SB memory words and streams them out.
// Optional feature macro: FM_SB_PB_GAP_EN adds pb_gap[7:0], idle cycles after each word.
module fm_sb_playback
    import fm_sb_pkg::*;
#(
    parameter int DW         = MON_DW_MAX,
    parameter int AW         = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = PB_FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  pb_mode_t            pb_mode,
    input  logic                pb_start,
    input  logic [AW-1:0]       pb_last_addr,
`ifdef FM_SB_PB_GAP_EN
    input  logic [7:0]          pb_gap,
`endif
    fm_sb_playback_if.master    pb_if,
    output logic                pb_busy,
    output logic                pb_done,
    output logic [31:0]         pb_words
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pb_state_t         state, state_nxt;
    pb_mode_t          mode_q;
    logic [AW-1:0]     last_q;
    logic [AW-1:0]     addr_q;
    logic              step_pend;
    logic [RD_LAT-1:0] inflight_sr;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_data;
    logic              start_ok, abort, room, issue, drain_done;
    logic              gap_open, vld, pop;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: ONESHOT drains after its last read; OFF aborts from anywhere.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (issue && mode_q == PB_ONESHOT && addr_q == last_q)
                    state_nxt = DRAIN;
            end
            DRAIN:   if (abort || drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and issue decode; a read only goes out if its return slot is guaranteed.
    always_comb begin
        start_ok    = (state == IDLE) && pb_start && (pb_mode != PB_OFF);
        abort       = (state != IDLE) && (pb_mode == PB_OFF);
        room        = (int'(fifo_cnt) + $countones(inflight_sr)) < FIFO_DEPTH;
        issue       = (state == RUN) && !abort && room && ((mode_q != PB_STEP) || step_pend);
        drain_done  = (inflight_sr == '0) && fifo_empty;
        pb_busy     = (state != IDLE);
        pb_if.mem_rd_en   = issue;
        pb_if.mem_rd_addr = addr_q;
    end

    // Run configuration, read address, pending step request and sticky done flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= PB_OFF;
            last_q    <= '0;
            addr_q    <= '0;
            step_pend <= 1'b0;
            pb_done   <= 1'b0;
        end else if (start_ok) begin
            mode_q    <= pb_mode;
            last_q    <= pb_last_addr;
            addr_q    <= '0;
            step_pend <= (pb_mode == PB_STEP);
            pb_done   <= 1'b0;
        end else begin
            if (issue) addr_q <= (addr_q == last_q) ? '0 : addr_q + AW'(1);
            // A new step pulse wins over the one being consumed this cycle.
            if (state == RUN && mode_q == PB_STEP && pb_start) step_pend <= 1'b1;
            else if (issue)                                    step_pend <= 1'b0;
            if (state == DRAIN && !abort && drain_done) pb_done <= 1'b1;
        end
    end

    // In-flight tracker: the top bit marks the cycle read data returns from memory.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) inflight_sr <= '0;
        else                 inflight_sr <= (inflight_sr << 1) | RD_LAT'(issue);
    end

    fm_sb_pb_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .wr_en   (inflight_sr[RD_LAT-1] && !abort),
        .wr_data (pb_if.mem_rd_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

`ifdef FM_SB_PB_GAP_EN
    logic [7:0] gap_q, gap_cnt;

    // Inter-word gap: reload after each transfer, count down to reopen the stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            if (start_ok) gap_q <= pb_gap;
            if (abort || start_ok) gap_cnt <= '0;
            else if (pop)          gap_cnt <= gap_q;
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;
        end
    end
    assign gap_open = (gap_cnt == '0);
`else
    assign gap_open = 1'b1;
`endif

    assign vld            = !fifo_empty && gap_open;
    assign pop            = vld && pb_if.pb_ready;
    assign pb_if.pb_vld   = vld;
    assign pb_if.pb_data  = vld ? fifo_data : '0;

    // Saturating count of transferred words since the last accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok)         pb_words <= '0;
        else if (pop && pb_words != '1) pb_words <= pb_words + 32'd1;
    end

endmodule
